// File: rtl/fir_pkg.sv
// Shared definitions for the FIR channel: sequencer states, tap counter width and
// default channel geometry used by the sequencer, input memory and coefficient ROM.
package fir_pkg;

    localparam int CNT_W           = 8;
    localparam int DRAIN_W         = 4;
    localparam int DEFAULT_LENGTH  = 64;
    localparam int DEFAULT_MAC_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        DONE
    } fir_seq_state_t;

    // Index of the final tap for a channel of the given length.
    function automatic logic [CNT_W-1:0] last_tap(input int length);
        return CNT_W'(length - 1);
    endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Handshake and datapath-control bundle between the FIR sequencer and its
// sample source/sink plus the input-memory/coefficient/MAC datapath.
interface fir_sequencer_if;
    import fir_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             load;
    logic [CNT_W-1:0] counter;
    logic             acc_clr;
    logic             mac_en;
    logic             busy;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output load,
        output counter,
        output acc_clr,
        output mac_en,
        output busy
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  load,
        input  counter,
        input  acc_clr,
        input  mac_en,
        input  busy
    );

endinterface

// File: rtl/fir_sequencer.sv
// Control FSM for one FIR channel: accepts a sample, sweeps the tap counter for the
// MAC, waits out the MAC pipeline latency, then offers the accumulated result.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int LENGTH  = DEFAULT_LENGTH,
    parameter int MAC_LAT = DEFAULT_MAC_LAT
) (
    input  logic            clk,
    input  logic            rst,
    fir_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0]   LAST_TAP   = last_tap(LENGTH);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MAC_LAT);

    fir_seq_state_t     state;
    fir_seq_state_t     state_next;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   counter_next;
    logic [DRAIN_W-1:0] drain;
    logic [DRAIN_W-1:0] drain_next;

    logic in_ready;
    logic out_valid;
    logic load;
    logic acc_clr;
    logic mac_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            drain   <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            drain   <= drain_next;
        end
    end

    // load/acc_clr follow in_valid combinationally so the memory and the
    // accumulator act on the very edge that completes the input handshake.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        drain_next   = drain;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        load         = 1'b0;
        acc_clr      = 1'b0;
        mac_en       = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                load     = bus.in_valid;
                acc_clr  = bus.in_valid;
                if (bus.in_valid) begin
                    state_next   = MAC;
                    counter_next = '0;
                end
            end

            MAC: begin
                mac_en = 1'b1;
                if (counter == LAST_TAP) begin
                    if (MAC_LAT == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = DRAIN;
                        drain_next = DRAIN_INIT;
                    end
                end else begin
                    counter_next = counter + CNT_W'(1);
                end
            end

            DRAIN: begin
                if (drain != '0) begin
                    drain_next = drain - DRAIN_W'(1);
                end
                if (drain <= DRAIN_W'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end
            end

            default: begin
                state_next   = IDLE;
                counter_next = '0;
                drain_next   = '0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.load      = load;
    assign bus.acc_clr   = acc_clr;
    assign bus.mac_en    = mac_en;
    assign bus.counter   = counter;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed self-checking bench for fir_sequencer with a small behavioural
// input-memory / unit-coefficient / MAC datapath hung off the main instance.
module tb_fir_sequencer;

    logic       clk;
    logic       rst;
    logic       model_clear;
    logic [7:0] sample_data;
    int         total;
    int         bad;

    fir_sequencer_if bus_a ();
    fir_sequencer_if bus_b ();

    fir_sequencer #(.LENGTH(4), .MAC_LAT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fir_sequencer #(.LENGTH(1), .MAC_LAT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: 4-deep shift memory, coefficients all 1, two-stage product pipe.
    logic [7:0]  mem [4];
    logic [1:0]  pipe_v;
    logic [15:0] pipe_p [2];
    logic [15:0] acc;

    always @(posedge clk) begin
        if (model_clear) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'd0;
            pipe_v    <= 2'b00;
            pipe_p[0] <= 16'd0;
            pipe_p[1] <= 16'd0;
            acc       <= 16'd0;
        end else begin
            if (bus_a.load) begin
                mem[0] <= sample_data;
                mem[1] <= mem[0];
                mem[2] <= mem[1];
                mem[3] <= mem[2];
            end
            pipe_v[0] <= bus_a.mac_en;
            pipe_p[0] <= 16'(mem[bus_a.counter[1:0]]) * 16'd1;
            pipe_v[1] <= pipe_v[0];
            pipe_p[1] <= pipe_p[0];
            if (bus_a.acc_clr) acc <= 16'd0;
            else if (pipe_v[1]) acc <= acc + pipe_p[1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_b.out_ready = 1'b0;
        sample_data = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        model_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if ({bus_a.in_ready, bus_a.busy, bus_a.out_valid, bus_a.load, bus_a.mac_en, bus_a.acc_clr} !== 6'b100000) begin
                bad++;
                $display("[TB] FAIL reset_idle cycle %0d: rdy/busy/ov/load/mac/clr got %b want 100000", i,
                         {bus_a.in_ready, bus_a.busy, bus_a.out_valid, bus_a.load, bus_a.mac_en, bus_a.acc_clr});
            end
            total++;
            if (bus_a.counter !== 8'd0) begin
                bad++;
                $display("[TB] FAIL reset_counter cycle %0d: got %0d want 0", i, bus_a.counter);
            end
            tick();
        end
        total++;
        if ({bus_b.in_ready, bus_b.busy, bus_b.out_valid} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL reset_short: rdy/busy/ov got %b want 100", {bus_b.in_ready, bus_b.busy, bus_b.out_valid});
        end
    endtask

    task automatic test_single_sample();
        sample_data = 8'd1;
        bus_a.in_valid = 1'b1;
        #1;
        total++;
        if ({bus_a.load, bus_a.acc_clr, bus_a.in_ready} !== 3'b111) begin
            bad++;
            $display("[TB] FAIL single_accept: load/clr/rdy got %b want 111", {bus_a.load, bus_a.acc_clr, bus_a.in_ready});
        end
        tick();
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({bus_a.mac_en, bus_a.busy, bus_a.in_ready, bus_a.load, bus_a.acc_clr} !== 5'b11000 || bus_a.counter !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL single_mac %0d: mac/busy/rdy/load/clr=%b counter=%0d want 11000 counter=%0d", i,
                         {bus_a.mac_en, bus_a.busy, bus_a.in_ready, bus_a.load, bus_a.acc_clr}, bus_a.counter, i);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({bus_a.mac_en, bus_a.busy, bus_a.out_valid} !== 3'b010) begin
                bad++;
                $display("[TB] FAIL single_drain %0d: mac/busy/ov got %b want 010", i, {bus_a.mac_en, bus_a.busy, bus_a.out_valid});
            end
            tick();
        end
        #1;
        total++;
        if ({bus_a.out_valid, bus_a.busy, bus_a.mac_en} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL single_done: ov/busy/mac got %b want 110", {bus_a.out_valid, bus_a.busy, bus_a.mac_en});
        end
        total++;
        if (acc !== 16'd1) begin
            bad++;
            $display("[TB] FAIL single_result: got %0d want 1", acc);
        end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        #1;
        total++;
        if ({bus_a.in_ready, bus_a.busy, bus_a.out_valid} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL single_return: rdy/busy/ov got %b want 100", {bus_a.in_ready, bus_a.busy, bus_a.out_valid});
        end
    endtask

    task automatic test_hold_done();
        int n;
        sample_data = 8'd2;
        bus_a.in_valid = 1'b1;
        bus_a.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus_a.load !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hold_no_load_busy %0d: got %b want 0", i, bus_a.load);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({bus_a.out_valid, bus_a.in_ready, bus_a.load} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL hold_done %0d: ov/rdy/load got %b want 100", i, {bus_a.out_valid, bus_a.in_ready, bus_a.load});
            end
            tick();
        end
        total++;
        if (acc !== 16'd3) begin
            bad++;
            $display("[TB] FAIL hold_result: got %0d want 3", acc);
        end
        sample_data = 8'd3;
        bus_a.out_ready = 1'b1;
        tick();
        total++;
        if ({bus_a.in_ready, bus_a.load, bus_a.busy, bus_a.out_valid} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL hold_reaccept: rdy/load/busy/ov got %b want 1100", {bus_a.in_ready, bus_a.load, bus_a.busy, bus_a.out_valid});
        end
        tick();
        bus_a.in_valid = 1'b0;
        #1;
        total++;
        if (bus_a.mac_en !== 1'b1 || bus_a.counter !== 8'd0) begin
            bad++;
            $display("[TB] FAIL hold_next_mac: mac=%b counter=%0d want 1/0", bus_a.mac_en, bus_a.counter);
        end
        n = 0;
        while (!bus_a.out_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!bus_a.out_valid || acc !== 16'd6) begin
            bad++;
            $display("[TB] FAIL hold_next_result: ov=%b acc=%0d want 1/6", bus_a.out_valid, acc);
        end
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int prev;
        int loads;
        int n;
        logic [7:0] last;
        prev = -1;
        loads = 0;
        last = 8'd0;
        sample_data = 8'd4;
        bus_a.in_valid = 1'b1;
        bus_a.out_ready = 1'b1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            #1;
            if (bus_a.load) begin
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev != 8) begin
                        bad++;
                        $display("[TB] FAIL b2b_period at cycle %0d: got %0d want 8", cyc, cyc - prev);
                    end
                end
                prev = cyc;
                loads++;
                last = sample_data;
            end
            if (bus_a.out_valid) begin
                total++;
                if (acc !== 16'(4 * int'(last) - 6)) begin
                    bad++;
                    $display("[TB] FAIL b2b_result sample %0d: got %0d want %0d", last, acc, 4 * int'(last) - 6);
                end
            end
            tick();
            if (cyc == prev) sample_data = sample_data + 8'd1;
        end
        bus_a.in_valid = 1'b0;
        total++;
        if (loads != 5) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d want 5", loads);
        end
        n = 0;
        while (!bus_a.out_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!bus_a.out_valid || acc !== 16'd26) begin
            bad++;
            $display("[TB] FAIL b2b_last: ov=%b acc=%0d want 1/26", bus_a.out_valid, acc);
        end
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_end_to_end();
        int exp_sum [4] = '{1, 3, 6, 10};
        int n;
        model_clear = 1'b1;
        tick();
        model_clear = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sample_data = 8'(s + 1);
            bus_a.in_valid = 1'b1;
            tick();
            bus_a.in_valid = 1'b0;
            n = 0;
            while (!bus_a.out_valid && n < 20) begin
                tick();
                n++;
            end
            total++;
            if (!bus_a.out_valid || acc !== 16'(exp_sum[s])) begin
                bad++;
                $display("[TB] FAIL e2e_result %0d: ov=%b acc=%0d want 1/%0d", s, bus_a.out_valid, acc, exp_sum[s]);
            end
            bus_a.out_ready = 1'b1;
            tick();
            bus_a.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        model_clear = 1'b1;
        tick();
        model_clear = 1'b0;
        sample_data = 8'd5;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        n = 0;
        while (bus_a.counter !== 8'd2 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (bus_a.counter !== 8'd2 || bus_a.mac_en !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_reach: counter=%0d mac=%b want 2/1", bus_a.counter, bus_a.mac_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus_a.busy, bus_a.in_ready, bus_a.out_valid, bus_a.mac_en} !== 4'b0100 || bus_a.counter !== 8'd0) begin
            bad++;
            $display("[TB] FAIL midrst_idle: busy/rdy/ov/mac=%b counter=%0d want 0100/0",
                     {bus_a.busy, bus_a.in_ready, bus_a.out_valid, bus_a.mac_en}, bus_a.counter);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (bus_a.out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrst_no_ov %0d: got %b want 0", i, bus_a.out_valid);
            end
        end
        sample_data = 8'd7;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        n = 0;
        while (!bus_a.out_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!bus_a.out_valid || acc !== 16'd12) begin
            bad++;
            $display("[TB] FAIL midrst_fresh: ov=%b acc=%0d want 1/12", bus_a.out_valid, acc);
        end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_short_channel();
        bus_b.in_valid = 1'b1;
        #1;
        total++;
        if (bus_b.load !== 1'b1) begin
            bad++;
            $display("[TB] FAIL short_accept: load got %b want 1", bus_b.load);
        end
        tick();
        bus_b.in_valid = 1'b0;
        #1;
        total++;
        if ({bus_b.mac_en, bus_b.busy, bus_b.out_valid} !== 3'b110 || bus_b.counter !== 8'd0) begin
            bad++;
            $display("[TB] FAIL short_mac: mac/busy/ov=%b counter=%0d want 110/0", {bus_b.mac_en, bus_b.busy, bus_b.out_valid}, bus_b.counter);
        end
        tick();
        total++;
        if ({bus_b.mac_en, bus_b.out_valid, bus_b.busy} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL short_done: mac/ov/busy got %b want 011", {bus_b.mac_en, bus_b.out_valid, bus_b.busy});
        end
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
        #1;
        total++;
        if ({bus_b.busy, bus_b.in_ready, bus_b.out_valid} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL short_return: busy/rdy/ov got %b want 010", {bus_b.busy, bus_b.in_ready, bus_b.out_valid});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_sample();
        test_hold_done();
        test_back_to_back();
        test_end_to_end();
        test_reset_mid_sweep();
        test_short_channel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
